// File: rtl/mips_hilo_muldiv.sv
// mips_hilo_muldiv: iterative 33-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO,
// with MTHI/MTLO writes accepted only while idle.
module mips_hilo_muldiv (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        is_div, neg_q, neg_r;
    logic [31:0] s, w;
    logic [63:0] acc;
    logic        rs_neg, rt_neg, div_zero, ge;
    logic [31:0] rs_mag, rt_mag, quo, rem;
    logic [32:0] add, rem_t, sub;
    logic [63:0] prod;
    // s holds the static operand (multiplicand or divisor), w the shifting one
    // (multiplier consumed LSB-first, or dividend consumed MSB-first as quotient fills in).
    always_comb begin
        rs_neg   = !op[0] && rs_data[31];
        rt_neg   = !op[0] && rt_data[31];
        rs_mag   = rs_neg ? -rs_data : rs_data;
        rt_mag   = rt_neg ? -rt_data : rt_data;
        div_zero = op[1] && (rt_data == 32'd0);
        add      = {1'b0, acc[63:32]} + {1'b0, (w[0] ? s : 32'd0)};
        rem_t    = {acc[63:32], w[31]};
        sub      = rem_t - {1'b0, s};
        ge       = rem_t >= {1'b0, s};
        prod     = neg_q ? -acc : acc;
        quo      = neg_q ? -w : w;
        rem      = neg_r ? -acc[63:32] : acc[63:32];
    end
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            s      <= 32'd0;
            w      <= 32'd0;
            acc    <= 64'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            done <= state == FIN;
            if (state == IDLE) begin
                if (start) begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    cnt    <= 5'd0;
                    acc    <= 64'd0;
                    is_div <= op[1];
                    s      <= op[1] ? rt_mag : rs_mag;
                    // divide by zero keeps the raw dividend so it falls out as HI unmodified
                    w      <= op[1] ? (div_zero ? rs_data : rs_mag) : rt_mag;
                    neg_q  <= !div_zero && (rs_neg ^ rt_neg);
                    neg_r  <= !div_zero && rs_neg;
                end else begin
                    if (mthi) hi <= rs_data;
                    if (mtlo) lo <= rs_data;
                end
            end else if (state == RUN) begin
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) state <= FIN;
                if (is_div) begin
                    acc[63:32] <= ge ? sub[31:0] : rem_t[31:0];
                    w          <= {w[30:0], ge};
                end else begin
                    acc <= {add, acc[31:1]};
                    w   <= w >> 1;
                end
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
                hi    <= is_div ? rem : prod[63:32];
                lo    <= is_div ? quo : prod[31:0];
            end
        end
    end
endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// tb_mips_hilo_muldiv: directed-vector bench for the HI/LO multiply/divide unit.
module tb_mips_hilo_muldiv;
    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int checks = 0;
    int failures = 0;

    mips_hilo_muldiv dut (
        .CLK(CLK), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit intrude, input bit mt_on_start);
        logic [31:0] h0, l0;
        int n, dn;
        bit stable;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op = o; rs_data = a; rt_data = b; mthi = mt_on_start; mtlo = mt_on_start;
        @(posedge CLK); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
        n = 0; dn = 0; stable = 1'b1;
        while (busy && n < 40) begin
            if (intrude && n == 5) begin
                start = 1'b1; op = 2'd2; rs_data = 32'hDEADBEEF; rt_data = 32'd1; mthi = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(posedge CLK); #1;
            n++;
            if (busy && (hi !== h0 || lo !== l0)) stable = 1'b0;
            if (busy && done) dn++;
        end
        start = 1'b0; mthi = 1'b0;
        chk({tag, " cycles"}, n, 32'd33);
        chk({tag, " hilo_stable"}, {31'd0, stable}, 32'd1);
        chk({tag, " early_done"}, dn, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        @(posedge CLK); #1;
        chk({tag, " done_cleared"}, {31'd0, done}, 32'd0);
        chk({tag, " idle_after"}, {31'd0, busy}, 32'd0);
        chk({tag, " hi_held"}, hi, eh);
    endtask

    initial begin
        #12;
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        @(posedge CLK); #1;
        mtlo = 1'b1; rs_data = 32'h00012345;
        @(posedge CLK); #1;
        mtlo = 1'b0;
        chk("mtlo lo", lo, 32'h00012345);
        chk("mtlo hi", hi, 32'd0);
        mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hA5A5_0001;
        @(posedge CLK); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthilo hi", hi, 32'hA5A5_0001);
        chk("mthilo lo", lo, 32'hA5A5_0001);

        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run_op("mult_zero", 2'd0, 32'hFFFFFFFD, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
        run_op("mult_negneg", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("div_negdiv", 2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("divu_zero", 2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_zero", 2'd2, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op("divu_big", 2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0);
        run_op("multu_intrude", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
        run_op("start_vs_mt", 2'd1, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0, 1'b1);

        start = 1'b1; op = 2'd3; rs_data = 32'h00000064; rt_data = 32'h00000007;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #2 rst = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        #3 rst = 1'b1;
        run_op("multu_after_rst", 2'd1, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_hilo_muldiv.md
# mips_hilo_muldiv

Multi-cycle MIPS multiply/divide unit owning the architectural HI and LO registers. Operands arrive straight from the register file read ports (rs from DataOut1, rt from DataOut2). The unit executes MULT, MULTU, DIV and DIVU iteratively in 33 cycles and supports MTHI/MTLO writes. Its `hi`/`lo` outputs feed the MFHI/MFLO path back into the register file's DataIn.

## Interface
Parameters:
- none; data width is fixed at 32 bits and the iteration count at 32.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of CLK.
- start  in  1  request an operation; accepted only on an edge where busy=0.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
- rs_data  in  32  multiplicand / dividend; also MTHI/MTLO source.
- rt_data  in  32  multiplier / divisor.
- mthi  in  1  write rs_data into HI.
- mtlo  in  1  write rs_data into LO.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle pulse in the cycle after HI/LO are updated by an operation.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, start=1 on an edge:
  - latch op and operand magnitudes (|x| for signed ops, raw for unsigned);
  - latch result-sign flags;
  - clear the 64-bit working accumulator;
  - set iteration counter=0 and busy=1;
  - go to RUN.
- RUN, one iteration per edge, counter increments:
  - multiply: radix-2 shift-add over 32 multiplier bits into the 64-bit product;
  - divide: restoring shift-subtract, one quotient bit per edge;
  - after the 32nd iteration go to FINISH.
- FINISH, one edge:
  - apply sign correction (two's-complement negate);
  - write HI/LO, set busy=0, assert done for the next cycle;
  - go to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0]. MULT is negative iff the operand signs differ and neither operand is zero.
- Divide result: LO = quotient, HI = remainder.
  - Signed quotient is negated iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): still 33 cycles. Result is LO=0xFFFFFFFF, HI=rs_data as latched at start.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No trap.
- hi/lo keep their previous values throughout RUN. Only FINISH, mthi or mtlo change them.
- MTHI/MTLO:
  - in IDLE with start=0: the edge writes rs_data to HI (mthi) and/or LO (mtlo); both may assert together;
  - ignored while busy=1;
  - ignored on an edge where start is accepted (start wins).
- start while busy=1: ignored, with no queueing.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts the operation and leaves HI/LO at 0.

## Timing
- Accept edge E0: start=1 and busy=0. busy reads 1 after E0.
- Iterations run on edges E1..E32. FINISH executes on E33.
- After E33: hi/lo hold the new result, busy=0, done=1. done returns to 0 after E34 unless another operation finishes on that edge.
- A new start may be accepted on E34 (back-to-back throughput: one operation per 34 edges). done and a new accept may coincide.
- MTHI/MTLO latency: value visible on hi/lo one edge after the write edge.
- busy, done, hi and lo are all registered; no combinational path from inputs to outputs.

## Test plan
- Reset release: rst=0 then 1 -> hi=0, lo=0, busy=0, done=0. MTLO rs=0x00012345 -> lo=0x00012345 next cycle, hi still 0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> busy high for 33 cycles. After E33: hi=0xFFFFFFFE, lo=0x00000001, done pulses exactly once.
- MULT −3×7 (0xFFFFFFFD, 0x00000007) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x00000064/0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- During a busy MULTU:
  - assert start with op=DIV, plus mthi with rs=0xDEADBEEF -> both ignored;
  - hi/lo unchanged until E33, then hold the MULTU result;
  - no second done pulse.
- Reset mid-operation: assert rst=0 at iteration 10 of a DIVU -> busy=0 and hi=lo=0 immediately. After release, a fresh MULTU 6×7 gives lo=0x0000002A, hi=0.
